// File: rtl/rf_pkg.sv
// Shared register-file constants, typedefs and the round-robin pointer helper
// used by the writeback arbiter.
package rf_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int NUM_REGISTERS = 32;
  localparam int ADDRESS_WIDTH = $clog2(NUM_REGISTERS);

  typedef logic [ADDRESS_WIDTH-1:0] rf_addr_t;
  typedef logic [DATA_WIDTH-1:0]    rf_data_t;

  // Position after idx on a ring of n slots.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// scanning upward with wrap-around. Returns a one-hot grant and its index.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin shares the single RF write port,
// registers the winner, and tracks pending writes. Optional operand bypass: RF_WB_BYPASS_EN.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter  int DATA_WIDTH    = rf_pkg::DATA_WIDTH,
  parameter  int NUM_REGISTERS = rf_pkg::NUM_REGISTERS,
  parameter  int NUM_REQ       = 3,
  localparam int ADDRESS_WIDTH = $clog2(NUM_REGISTERS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid_in,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_rd_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data_in,
  output logic [NUM_REQ-1:0]                req_ready_out,
  input  logic                              issue_valid_in,
  input  logic [ADDRESS_WIDTH-1:0]          issue_rd_in,
  input  logic [ADDRESS_WIDTH-1:0]          rs1_in,
  input  logic [ADDRESS_WIDTH-1:0]          rs2_in,
  output logic                              rs1_pending_out,
  output logic                              rs2_pending_out,
  output logic                              wr_en_out,
  output logic [ADDRESS_WIDTH-1:0]          rd_out,
  output logic [DATA_WIDTH-1:0]             rd_data_out
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [DATA_WIDTH-1:0]             rs1_rf_data_in,
  input  logic [DATA_WIDTH-1:0]             rs2_rf_data_in,
  output logic [DATA_WIDTH-1:0]             rs1_data_out,
  output logic [DATA_WIDTH-1:0]             rs2_data_out
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       gnt_p0;
  logic [PTR_W-1:0]         gnt_idx_p0;
  logic [PTR_W-1:0]         ptr_q;
  logic                     vld_p0;
  logic [ADDRESS_WIDTH-1:0] rd_p0;
  logic [DATA_WIDTH-1:0]    data_p0;
  logic [NUM_REGISTERS-1:0] pending_q;
  logic [NUM_REGISTERS-1:0] pending_d;

  // Stage p0: combinational arbitration and payload select
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid_in),
    .ptr     (ptr_q),
    .gnt     (gnt_p0),
    .gnt_idx (gnt_idx_p0)
  );

  assign req_ready_out = gnt_p0;
  assign vld_p0        = |gnt_p0;
  assign rd_p0         = req_rd_in[int'(gnt_idx_p0)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign data_p0       = req_data_in[int'(gnt_idx_p0)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (vld_p0) begin
      ptr_q <= PTR_W'(rr_next(32'(gnt_idx_p0), NUM_REQ));
    end
  end

  // Stage p1: registered RF write port; x0 writes are consumed without a write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_out   <= 1'b0;
      rd_out      <= '0;
      rd_data_out <= '0;
    end else begin
      wr_en_out <= vld_p0 && (rd_p0 != '0);
      if (vld_p0) begin
        rd_out      <= rd_p0;
        rd_data_out <= data_p0;
      end
    end
  end

  // Clear happens on the commit edge; a same-edge issue overrides it.
  always_comb begin
    pending_d = pending_q;
    if (wr_en_out) pending_d[rd_out] = 1'b0;
    if (issue_valid_in && (issue_rd_in != '0)) pending_d[issue_rd_in] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

`ifdef RF_WB_BYPASS_EN
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit         = wr_en_out && (rd_out == rs1_in) && (rs1_in != '0);
  assign rs2_hit         = wr_en_out && (rd_out == rs2_in) && (rs2_in != '0);
  assign rs1_pending_out = pending_q[rs1_in] && !rs1_hit;
  assign rs2_pending_out = pending_q[rs2_in] && !rs2_hit;
  assign rs1_data_out    = rs1_hit ? rd_data_out : rs1_rf_data_in;
  assign rs2_data_out    = rs2_hit ? rd_data_out : rs2_rf_data_in;
`else
  assign rs1_pending_out = pending_q[rs1_in];
  assign rs2_pending_out = pending_q[rs2_in];
`endif

endmodule
